// File: rtl/issue_queue_br_pkg.sv
// Shared widths, micro-op codes and the queue entry layout for the branch issue queue.
// Wakeup bus indices double as positions in the packed WbAble/WbAddr/WbDate vectors.
package issue_queue_br_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int DATA_W      = 32;
    localparam int RENAME_W    = 7;
    localparam int MIC_OP_W    = 8;
    localparam int IMM_W       = 26;
    localparam int ROB_PTR_W   = 6;
    localparam int NUM_WB      = 5;

    localparam int WB_ALU1 = 0;
    localparam int WB_ALU2 = 1;
    localparam int WB_MUL  = 2;
    localparam int WB_CSR  = 3;
    localparam int WB_BRU  = 4;

    localparam logic [MIC_OP_W-1:0] MOP_NOP  = 8'h00;
    localparam logic [MIC_OP_W-1:0] MOP_BEQ  = 8'h51;
    localparam logic [MIC_OP_W-1:0] MOP_BNE  = 8'h52;
    localparam logic [MIC_OP_W-1:0] MOP_BLT  = 8'h53;
    localparam logic [MIC_OP_W-1:0] MOP_BGE  = 8'h54;
    localparam logic [MIC_OP_W-1:0] MOP_BLTU = 8'h55;
    localparam logic [MIC_OP_W-1:0] MOP_BGEU = 8'h56;
    localparam logic [MIC_OP_W-1:0] MOP_JAL  = 8'h57;
    localparam logic [MIC_OP_W-1:0] MOP_JALR = 8'h58;

    typedef struct packed {
        logic [INST_ADDR_W-1:0] pc;
        logic [MIC_OP_W-1:0]    mop;
        logic                   src1_able;
        logic                   src1_rdy;
        logic [RENAME_W-1:0]    src1_tag;
        logic [DATA_W-1:0]      src1_dat;
        logic                   src2_able;
        logic                   src2_rdy;
        logic [RENAME_W-1:0]    src2_tag;
        logic [DATA_W-1:0]      src2_dat;
        logic [IMM_W-1:0]       imm;
        logic                   rd_able;
        logic [RENAME_W-1:0]    rd_addr;
        logic                   mode;
        logic [INST_ADDR_W-1:0] redir;
        logic [ROB_PTR_W-1:0]   rob_ptr;
    } iq_entry_t;

endpackage

// File: rtl/issue_queue_br_if.sv
// Dispatch, wakeup-broadcast and issue bundle between rename, the branch issue queue and the branch unit.
interface issue_queue_br_if #(
    parameter int MOP_W = issue_queue_br_pkg::MIC_OP_W,
    parameter int PTR_W = 3
);
    import issue_queue_br_pkg::*;

    logic                          InValid;
    logic                          InReady;
    logic [INST_ADDR_W-1:0]        InPc;
    logic [MOP_W-1:0]              InMop;
    logic                          InSrc1Able;
    logic                          InSrc2Able;
    logic                          InSrc1Ready;
    logic                          InSrc2Ready;
    logic [RENAME_W-1:0]           InSrc1Addr;
    logic [RENAME_W-1:0]           InSrc2Addr;
    logic [DATA_W-1:0]             InSrc1Date;
    logic [DATA_W-1:0]             InSrc2Date;
    logic [IMM_W-1:0]              InImm;
    logic                          InRdAble;
    logic [RENAME_W-1:0]           InRdAddr;
    logic                          InMode;
    logic [INST_ADDR_W-1:0]        InReDirDate;
    logic [ROB_PTR_W-1:0]          InRobPtr;

    logic [NUM_WB-1:0]             WbAble;
    logic [NUM_WB-1:0][RENAME_W-1:0] WbAddr;
    logic [NUM_WB-1:0][DATA_W-1:0] WbDate;

    logic                          BruReqInst;

    logic [INST_ADDR_W-1:0]        OutPc;
    logic [MOP_W-1:0]              OutMop;
    logic                          OutSrc1Able;
    logic [RENAME_W-1:0]           OutSrc1Addr;
    logic [DATA_W-1:0]             OutSrc1Date;
    logic                          OutSrc2Able;
    logic [RENAME_W-1:0]           OutSrc2Addr;
    logic [DATA_W-1:0]             OutSrc2Date;
    logic [IMM_W-1:0]              OutImm;
    logic                          OutRdAble;
    logic [RENAME_W-1:0]           OutRdAddr;
    logic                          OutMode;
    logic [INST_ADDR_W-1:0]        OutReDirDate;
    logic [ROB_PTR_W-1:0]          OutRobPtr;
    logic [PTR_W:0]                Count;

    modport slave (
        input  InValid, InPc, InMop, InSrc1Able, InSrc2Able, InSrc1Ready, InSrc2Ready,
               InSrc1Addr, InSrc2Addr, InSrc1Date, InSrc2Date, InImm, InRdAble, InRdAddr,
               InMode, InReDirDate, InRobPtr, WbAble, WbAddr, WbDate, BruReqInst,
        output InReady, OutPc, OutMop, OutSrc1Able, OutSrc1Addr, OutSrc1Date, OutSrc2Able,
               OutSrc2Addr, OutSrc2Date, OutImm, OutRdAble, OutRdAddr, OutMode,
               OutReDirDate, OutRobPtr, Count
    );

    modport master (
        output InValid, InPc, InMop, InSrc1Able, InSrc2Able, InSrc1Ready, InSrc2Ready,
               InSrc1Addr, InSrc2Addr, InSrc1Date, InSrc2Date, InImm, InRdAble, InRdAddr,
               InMode, InReDirDate, InRobPtr, WbAble, WbAddr, WbDate, BruReqInst,
        input  InReady, OutPc, OutMop, OutSrc1Able, OutSrc1Addr, OutSrc1Date, OutSrc2Able,
               OutSrc2Addr, OutSrc2Date, OutImm, OutRdAble, OutRdAddr, OutMode,
               OutReDirDate, OutRobPtr, Count
    );

endinterface

// File: rtl/issue_queue_br_src_wakeup.sv
// Single source-operand wakeup: already-ready sources pass through, otherwise the highest-priority
// matching broadcast (Bru > Alu1 > Alu2 > Mul > Csr) supplies ready and data. Purely combinational.
module br_iq_src_wakeup
    import issue_queue_br_pkg::*;
(
    input  logic [RENAME_W-1:0]             tag,
    input  logic                            ready,
    input  logic [DATA_W-1:0]               data,
    input  logic [NUM_WB-1:0]               WbAble,
    input  logic [NUM_WB-1:0][RENAME_W-1:0] WbAddr,
    input  logic [NUM_WB-1:0][DATA_W-1:0]   WbDate,
    output logic                            next_ready,
    output logic [DATA_W-1:0]               next_data
);

    logic [NUM_WB-1:0] hit;

    always_comb begin
        for (int k = 0; k < NUM_WB; k++) begin
            hit[k] = WbAble[k] && (WbAddr[k] == tag);
        end
    end

    always_comb begin
        next_ready = ready;
        next_data  = data;
        if (!ready) begin
            next_ready = |hit;
            if (hit[WB_BRU])       next_data = WbDate[WB_BRU];
            else if (hit[WB_ALU1]) next_data = WbDate[WB_ALU1];
            else if (hit[WB_ALU2]) next_data = WbDate[WB_ALU2];
            else if (hit[WB_MUL])  next_data = WbDate[WB_MUL];
            else if (hit[WB_CSR])  next_data = WbDate[WB_CSR];
        end
    end

endmodule

// File: rtl/issue_queue_br.sv
// In-order branch/jump issue queue with operand capture; registered issue bundle one clock after the
// head is ready and BruReqInst is high. InReady = !full from registered pointers; Flash/reset clear all.
module issue_queue_br
    import issue_queue_br_pkg::*;
#(
    parameter int                DEPTH   = 8,
    parameter int                PTR_W   = 3,
    parameter int                MOP_W   = MIC_OP_W,
    parameter logic [MOP_W-1:0]  NOP_MOP = MOP_NOP
)(
    input  logic              Clk,
    input  logic              Rest,
    input  logic              Flash,
    issue_queue_br_if.slave   io
);

    iq_entry_t         mem_q [DEPTH];
    iq_entry_t         mem_d [DEPTH];
    iq_entry_t         enq_entry;
    iq_entry_t         out_q;
    logic [PTR_W:0]    head_q, tail_q;
    logic [PTR_W-1:0]  head_idx, tail_idx;
    logic              empty, full, enq, iss;

    logic [DEPTH-1:0]  wk1_rdy, wk2_rdy;
    logic [DATA_W-1:0] wk1_dat [DEPTH];
    logic [DATA_W-1:0] wk2_dat [DEPTH];
    logic              enq1_rdy, enq2_rdy;
    logic [DATA_W-1:0] enq1_dat, enq2_dat;

    assign head_idx = head_q[PTR_W-1:0];
    assign tail_idx = tail_q[PTR_W-1:0];
    assign empty    = (head_q == tail_q);
    assign full     = (head_q[PTR_W] != tail_q[PTR_W]) && (head_idx == tail_idx);
    assign enq      = io.InValid && !full && !Flash;
    assign iss      = !empty && mem_q[head_idx].src1_rdy && mem_q[head_idx].src2_rdy
                      && io.BruReqInst && !Flash;

    for (genvar i = 0; i < DEPTH; i++) begin : g_wake
        br_iq_src_wakeup u_src1 (
            .tag(mem_q[i].src1_tag), .ready(mem_q[i].src1_rdy), .data(mem_q[i].src1_dat),
            .WbAble(io.WbAble), .WbAddr(io.WbAddr), .WbDate(io.WbDate),
            .next_ready(wk1_rdy[i]), .next_data(wk1_dat[i])
        );
        br_iq_src_wakeup u_src2 (
            .tag(mem_q[i].src2_tag), .ready(mem_q[i].src2_rdy), .data(mem_q[i].src2_dat),
            .WbAble(io.WbAble), .WbAddr(io.WbAddr), .WbDate(io.WbDate),
            .next_ready(wk2_rdy[i]), .next_data(wk2_dat[i])
        );
    end

    // An unused source counts as ready so it never blocks issue or picks up a broadcast.
    br_iq_src_wakeup u_enq_src1 (
        .tag(io.InSrc1Addr), .ready(!io.InSrc1Able || io.InSrc1Ready), .data(io.InSrc1Date),
        .WbAble(io.WbAble), .WbAddr(io.WbAddr), .WbDate(io.WbDate),
        .next_ready(enq1_rdy), .next_data(enq1_dat)
    );
    br_iq_src_wakeup u_enq_src2 (
        .tag(io.InSrc2Addr), .ready(!io.InSrc2Able || io.InSrc2Ready), .data(io.InSrc2Date),
        .WbAble(io.WbAble), .WbAddr(io.WbAddr), .WbDate(io.WbDate),
        .next_ready(enq2_rdy), .next_data(enq2_dat)
    );

    always_comb begin
        enq_entry           = '0;
        enq_entry.pc        = io.InPc;
        enq_entry.mop       = io.InMop;
        enq_entry.src1_able = io.InSrc1Able;
        enq_entry.src1_rdy  = enq1_rdy;
        enq_entry.src1_tag  = io.InSrc1Addr;
        enq_entry.src1_dat  = enq1_dat;
        enq_entry.src2_able = io.InSrc2Able;
        enq_entry.src2_rdy  = enq2_rdy;
        enq_entry.src2_tag  = io.InSrc2Addr;
        enq_entry.src2_dat  = enq2_dat;
        enq_entry.imm       = io.InImm;
        enq_entry.rd_able   = io.InRdAble;
        enq_entry.rd_addr   = io.InRdAddr;
        enq_entry.mode      = io.InMode;
        enq_entry.redir     = io.InReDirDate;
        enq_entry.rob_ptr   = io.InRobPtr;
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i]          = mem_q[i];
            mem_d[i].src1_rdy = wk1_rdy[i];
            mem_d[i].src1_dat = wk1_dat[i];
            mem_d[i].src2_rdy = wk2_rdy[i];
            mem_d[i].src2_dat = wk2_dat[i];
        end
        if (enq) mem_d[tail_idx] = enq_entry;
    end

    // Entry payload needs no reset: validity lives entirely in the pointers.
    always_ff @(posedge Clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge Clk) begin
        if (!Rest || Flash) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            if (enq) tail_q <= tail_q + 1'b1;
            if (iss) head_q <= head_q + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rest) begin
            out_q     <= '0;
            out_q.mop <= NOP_MOP;
        end else if (iss) begin
            out_q <= mem_q[head_idx];
        end else begin
            out_q.mop     <= NOP_MOP;
            out_q.rd_able <= 1'b0;
        end
    end

    assign io.InReady      = !full;
    assign io.Count        = tail_q - head_q;
    assign io.OutPc        = out_q.pc;
    assign io.OutMop       = out_q.mop;
    assign io.OutSrc1Able  = out_q.src1_able;
    assign io.OutSrc1Addr  = out_q.src1_tag;
    assign io.OutSrc1Date  = out_q.src1_dat;
    assign io.OutSrc2Able  = out_q.src2_able;
    assign io.OutSrc2Addr  = out_q.src2_tag;
    assign io.OutSrc2Date  = out_q.src2_dat;
    assign io.OutImm       = out_q.imm;
    assign io.OutRdAble    = out_q.rd_able;
    assign io.OutRdAddr    = out_q.rd_addr;
    assign io.OutMode      = out_q.mode;
    assign io.OutReDirDate = out_q.redir;
    assign io.OutRobPtr    = out_q.rob_ptr;

endmodule

// File: tb/tb_issue_queue_br.sv
// Scenario bench for issue_queue_br: expected issues are queued at dispatch and checked in order
// by a negedge monitor; each scenario task also checks timing, occupancy and handshake inline.
module tb_issue_queue_br;
    import issue_queue_br_pkg::*;

    typedef struct packed {
        logic [31:0] pc;
        logic [7:0]  mop;
        logic        a1;
        logic [6:0]  t1;
        logic [31:0] d1;
        logic        a2;
        logic [6:0]  t2;
        logic [31:0] d2;
        logic [25:0] imm;
        logic        rd_able;
        logic [6:0]  rd_addr;
        logic        mode;
        logic [31:0] redir;
        logic [5:0]  rob;
    } exp_t;

    logic Clk;
    logic Rest;
    logic Flash;
    int   total = 0;
    int   bad   = 0;
    bit   mon_en = 0;
    exp_t sb[$];

    issue_queue_br_if io ();

    issue_queue_br dut (
        .Clk  (Clk),
        .Rest (Rest),
        .Flash(Flash),
        .io   (io)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Scoreboard monitor: every non-NOP issue must match the oldest outstanding dispatch.
    always @(negedge Clk) begin
        if (mon_en && io.OutMop !== MOP_NOP) begin
            exp_t obs;
            obs = '{io.OutPc, io.OutMop, io.OutSrc1Able, io.OutSrc1Addr, io.OutSrc1Date,
                    io.OutSrc2Able, io.OutSrc2Addr, io.OutSrc2Date, io.OutImm, io.OutRdAble,
                    io.OutRdAddr, io.OutMode, io.OutReDirDate, io.OutRobPtr};
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_issue: got pc=%h mop=%h, expected no issue", io.OutPc, io.OutMop);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (obs !== e) begin
                    bad++;
                    $display("FAIL issue_bundle: got %h, expected %h", obs, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic enq_drive(input logic [31:0] pc, input logic [7:0] mop,
                             input logic a1, input logic r1, input logic [6:0] t1, input logic [31:0] d1,
                             input logic a2, input logic r2, input logic [6:0] t2, input logic [31:0] d2);
        io.InValid     = 1'b1;
        io.InPc        = pc;
        io.InMop       = mop;
        io.InSrc1Able  = a1;
        io.InSrc1Ready = r1;
        io.InSrc1Addr  = t1;
        io.InSrc1Date  = d1;
        io.InSrc2Able  = a2;
        io.InSrc2Ready = r2;
        io.InSrc2Addr  = t2;
        io.InSrc2Date  = d2;
        io.InImm       = pc[27:2];
        io.InRdAble    = 1'b1;
        io.InRdAddr    = pc[8:2];
        io.InMode      = pc[2];
        io.InReDirDate = pc + 32'h100;
        io.InRobPtr    = pc[7:2];
    endtask

    task automatic push(input logic [31:0] pc, input logic [7:0] mop,
                        input logic a1, input logic [6:0] t1, input logic [31:0] d1,
                        input logic a2, input logic [6:0] t2, input logic [31:0] d2);
        sb.push_back('{pc, mop, a1, t1, d1, a2, t2, d2, pc[27:2], 1'b1, pc[8:2], pc[2],
                       pc + 32'h100, pc[7:2]});
    endtask

    task automatic wb_set(input int k, input logic [6:0] tag, input logic [31:0] dat);
        io.WbAble[k] = 1'b1;
        io.WbAddr[k] = tag;
        io.WbDate[k] = dat;
    endtask

    task automatic wb_clear();
        io.WbAble = '0;
        io.WbAddr = '0;
        io.WbDate = '0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: %0d issues outstanding, expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        Rest = 1'b0;
        tick();
        tick();
        Rest = 1'b1;
        mon_en = 1'b1;
        total++; if (io.InReady !== 1'b1) begin bad++; $display("FAIL reset_inready: got %b, expected 1", io.InReady); end
        total++; if (io.Count !== 4'd0) begin bad++; $display("FAIL reset_count: got %0d, expected 0", io.Count); end
        total++; if (io.OutMop !== MOP_NOP) begin bad++; $display("FAIL reset_outmop: got %h, expected %h", io.OutMop, MOP_NOP); end
        total++; if (io.OutPc !== 32'h0 || io.OutRdAble !== 1'b0 || io.OutSrc1Date !== 32'h0)
            begin bad++; $display("FAIL reset_outbundle: got pc=%h rd=%b d1=%h, expected zeros", io.OutPc, io.OutRdAble, io.OutSrc1Date); end
    endtask

    task automatic test_basic();
        io.BruReqInst = 1'b1;
        enq_drive(32'h1000, MOP_BEQ, 1, 1, 7'h01, 32'd5, 1, 1, 7'h02, 32'd5);
        push(32'h1000, MOP_BEQ, 1, 7'h01, 32'd5, 1, 7'h02, 32'd5);
        tick();
        io.InValid = 1'b0;
        total++; if (io.Count !== 4'd1) begin bad++; $display("FAIL basic_count1: got %0d, expected 1", io.Count); end
        total++; if (io.OutMop !== MOP_NOP) begin bad++; $display("FAIL basic_no_bypass: got %h, expected NOP", io.OutMop); end
        tick();
        total++; if (io.OutMop !== MOP_BEQ || io.OutPc !== 32'h1000)
            begin bad++; $display("FAIL basic_issue: got mop=%h pc=%h, expected 51/00001000", io.OutMop, io.OutPc); end
        total++; if (io.Count !== 4'd0) begin bad++; $display("FAIL basic_count0: got %0d, expected 0", io.Count); end
        drain("basic");
    endtask

    task automatic test_wakeup();
        io.BruReqInst = 1'b1;
        enq_drive(32'h2000, MOP_BNE, 1, 0, 7'h12, 32'h0, 0, 0, 7'h00, 32'h7);
        push(32'h2000, MOP_BNE, 1, 7'h12, 32'hDEAD, 0, 7'h00, 32'h7);
        tick();
        io.InValid = 1'b0;
        wb_set(WB_ALU1, 7'h12, 32'hDEAD);
        tick();
        wb_clear();
        total++; if (io.OutMop !== MOP_NOP) begin bad++; $display("FAIL wake_early: got %h at t+1, expected NOP", io.OutMop); end
        tick();
        total++; if (io.OutMop !== MOP_BNE || io.OutSrc1Date !== 32'hDEAD)
            begin bad++; $display("FAIL wake_issue: got mop=%h d1=%h, expected 52/0000dead", io.OutMop, io.OutSrc1Date); end
        drain("wakeup");

        // Bru outranks Alu1 and Csr; a Bru hit on another tag is ignored.
        enq_drive(32'h2100, MOP_BLT, 0, 0, 7'h00, 32'h1, 1, 0, 7'h33, 32'h0);
        push(32'h2100, MOP_BLT, 0, 7'h00, 32'h1, 1, 7'h33, 32'h2222);
        tick();
        io.InValid = 1'b0;
        wb_set(WB_ALU1, 7'h33, 32'h1111);
        wb_set(WB_BRU, 7'h33, 32'h2222);
        wb_set(WB_CSR, 7'h33, 32'h3333);
        tick();
        wb_clear();
        tick();
        total++; if (io.OutSrc2Date !== 32'h2222) begin bad++; $display("FAIL prio_bru: got %h, expected 2222", io.OutSrc2Date); end

        enq_drive(32'h2200, MOP_BLTU, 0, 0, 7'h00, 32'h1, 1, 0, 7'h34, 32'h0);
        push(32'h2200, MOP_BLTU, 0, 7'h00, 32'h1, 1, 7'h34, 32'hAAAA);
        tick();
        io.InValid = 1'b0;
        wb_set(WB_BRU, 7'h35, 32'hEEEE);
        wb_set(WB_ALU2, 7'h34, 32'hAAAA);
        wb_set(WB_MUL, 7'h34, 32'hBBBB);
        wb_set(WB_CSR, 7'h34, 32'hCCCC);
        tick();
        wb_clear();
        tick();
        total++; if (io.OutSrc2Date !== 32'hAAAA) begin bad++; $display("FAIL prio_alu2: got %h, expected aaaa", io.OutSrc2Date); end
        drain("priority");
    endtask

    task automatic test_in_order();
        io.BruReqInst = 1'b1;
        enq_drive(32'h3000, MOP_BEQ, 1, 0, 7'h00, 32'h0, 1, 1, 7'h09, 32'h99);
        push(32'h3000, MOP_BEQ, 1, 7'h00, 32'h77, 1, 7'h09, 32'h99);
        tick();
        enq_drive(32'h3004, MOP_BGE, 0, 0, 7'h00, 32'h1, 0, 0, 7'h00, 32'h2);
        push(32'h3004, MOP_BGE, 0, 7'h00, 32'h1, 0, 7'h00, 32'h2);
        tick();
        io.InValid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (io.OutMop !== MOP_NOP) begin bad++; $display("FAIL order_blocked: got %h, expected NOP", io.OutMop); end
        end
        total++; if (io.Count !== 4'd2) begin bad++; $display("FAIL order_count: got %0d, expected 2", io.Count); end
        wb_set(WB_ALU2, 7'h00, 32'h77);
        tick();
        wb_clear();
        tick();
        total++; if (io.OutPc !== 32'h3000) begin bad++; $display("FAIL order_first: got %h, expected 3000", io.OutPc); end
        tick();
        total++; if (io.OutPc !== 32'h3004) begin bad++; $display("FAIL order_second: got %h, expected 3004", io.OutPc); end
        drain("in_order");
    endtask

    task automatic test_back_to_back();
        io.BruReqInst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            enq_drive(32'h4000 + 32'(4 * i), MOP_JAL, 0, 0, 7'h00, 32'(i), 0, 0, 7'h00, 32'(i + 10));
            push(32'h4000 + 32'(4 * i), MOP_JAL, 0, 7'h00, 32'(i), 0, 7'h00, 32'(i + 10));
            tick();
            total++; if (io.Count !== 4'd1) begin bad++; $display("FAIL b2b_count_%0d: got %0d, expected 1", i, io.Count); end
        end
        io.InValid = 1'b0;
        tick();
        total++; if (io.Count !== 4'd0) begin bad++; $display("FAIL b2b_final: got %0d, expected 0", io.Count); end
        drain("back_to_back");
    endtask

    task automatic test_full();
        io.BruReqInst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            enq_drive(32'h5000 + 32'(4 * i), MOP_BGEU, 1, 0, 7'(8'h40 + i), 32'h0, 0, 0, 7'h00, 32'h5);
            push(32'h5000 + 32'(4 * i), MOP_BGEU, 1, 7'(8'h40 + i), 32'hC000 + 32'(i), 0, 7'h00, 32'h5);
            tick();
        end
        total++; if (io.Count !== 4'd8 || io.InReady !== 1'b0)
            begin bad++; $display("FAIL full_state: got count=%0d ready=%b, expected 8/0", io.Count, io.InReady); end
        enq_drive(32'h5FF0, MOP_BEQ, 0, 0, 7'h00, 32'h0, 0, 0, 7'h00, 32'h0);
        tick();
        io.InValid = 1'b0;
        total++; if (io.Count !== 4'd8) begin bad++; $display("FAIL full_ninth: got %0d, expected 8", io.Count); end
        wb_set(WB_CSR, 7'h40, 32'hC000);
        tick();
        wb_clear();
        io.BruReqInst = 1'b1;
        enq_drive(32'h6000, MOP_BEQ, 0, 0, 7'h00, 32'h0, 0, 0, 7'h00, 32'h0);
        total++; if (io.InReady !== 1'b0) begin bad++; $display("FAIL full_ready_hold: got %b, expected 0", io.InReady); end
        tick();
        io.InValid = 1'b0;
        total++; if (io.InReady !== 1'b1 || io.Count !== 4'd7)
            begin bad++; $display("FAIL full_dequeue: got ready=%b count=%0d, expected 1/7", io.InReady, io.Count); end
        for (int i = 1; i < 8; i++) begin
            wb_set(WB_ALU1, 7'(8'h40 + i), 32'hC000 + 32'(i));
            tick();
        end
        wb_clear();
        drain("full");
    endtask

    task automatic test_enq_wakeup();
        io.BruReqInst = 1'b0;
        enq_drive(32'h7000, MOP_BGE, 0, 0, 7'h00, 32'h11, 1, 0, 7'h05, 32'h0);
        push(32'h7000, MOP_BGE, 0, 7'h00, 32'h11, 1, 7'h05, 32'h5555);
        wb_set(WB_MUL, 7'h05, 32'h5555);
        tick();
        io.InValid = 1'b0;
        wb_clear();
        tick();
        io.BruReqInst = 1'b1;
        tick();
        total++; if (io.OutMop !== MOP_BGE || io.OutSrc2Date !== 32'h5555)
            begin bad++; $display("FAIL enq_wake: got mop=%h d2=%h, expected 54/00005555", io.OutMop, io.OutSrc2Date); end
        drain("enq_wakeup");
    endtask

    task automatic test_bru_req();
        io.BruReqInst = 1'b0;
        enq_drive(32'h8000, MOP_JALR, 0, 0, 7'h00, 32'h8, 0, 0, 7'h00, 32'h9);
        push(32'h8000, MOP_JALR, 0, 7'h00, 32'h8, 0, 7'h00, 32'h9);
        tick();
        io.InValid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (io.OutMop !== MOP_NOP) begin bad++; $display("FAIL bru_stall: got %h, expected NOP", io.OutMop); end
        end
        total++; if (io.Count !== 4'd1) begin bad++; $display("FAIL bru_count: got %0d, expected 1", io.Count); end
        io.BruReqInst = 1'b1;
        tick();
        total++; if (io.OutMop !== MOP_JALR) begin bad++; $display("FAIL bru_go: got %h, expected 58", io.OutMop); end
        drain("bru_req");
    endtask

    task automatic test_flush();
        io.BruReqInst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            enq_drive(32'h9000 + 32'(4 * i), MOP_BEQ, 0, 0, 7'h00, 32'h1, 0, 0, 7'h00, 32'h1);
            tick();
        end
        total++; if (io.Count !== 4'd3) begin bad++; $display("FAIL flush_pre: got %0d, expected 3", io.Count); end
        enq_drive(32'h9999, MOP_BNE, 0, 0, 7'h00, 32'h1, 0, 0, 7'h00, 32'h1);
        io.BruReqInst = 1'b1;
        Flash = 1'b1;
        tick();
        Flash = 1'b0;
        io.InValid = 1'b0;
        total++; if (io.Count !== 4'd0 || io.InReady !== 1'b1)
            begin bad++; $display("FAIL flush_state: got count=%0d ready=%b, expected 0/1", io.Count, io.InReady); end
        total++; if (io.OutMop !== MOP_NOP || io.OutRdAble !== 1'b0)
            begin bad++; $display("FAIL flush_out: got mop=%h rd=%b, expected NOP/0", io.OutMop, io.OutRdAble); end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (io.OutMop !== MOP_NOP) begin bad++; $display("FAIL flush_dropped: got %h, expected NOP", io.OutMop); end
        end

        io.BruReqInst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            enq_drive(32'hA000 + 32'(4 * i), MOP_BLT, 0, 0, 7'h00, 32'h1, 0, 0, 7'h00, 32'h1);
            tick();
        end
        io.InValid = 1'b0;
        Rest = 1'b0;
        tick();
        Rest = 1'b1;
        total++; if (io.Count !== 4'd0 || io.InReady !== 1'b1 || io.OutPc !== 32'h0 || io.OutMop !== MOP_NOP)
            begin bad++; $display("FAIL midreset: got count=%0d ready=%b pc=%h mop=%h, expected 0/1/0/NOP",
                                  io.Count, io.InReady, io.OutPc, io.OutMop); end
        io.BruReqInst = 1'b1;
        tick();
        tick();
        total++; if (io.Count !== 4'd0) begin bad++; $display("FAIL midreset_idle: got %0d, expected 0", io.Count); end
        drain("flush");
    endtask

    initial begin
        Rest  = 1'b0;
        Flash = 1'b0;
        io.InValid = 1'b0;
        io.BruReqInst = 1'b0;
        enq_drive(32'h0, MOP_NOP, 0, 0, 7'h00, 32'h0, 0, 0, 7'h00, 32'h0);
        io.InValid = 1'b0;
        wb_clear();

        test_reset();
        test_basic();
        test_wakeup();
        test_in_order();
        test_back_to_back();
        test_full();
        test_enq_wakeup();
        test_bru_req();
        test_flush();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/issue_queue_br.md
Name: issue_queue_br

Overview:
- In-order issue queue for branch and jump micro-ops; sits between rename/dispatch and the branch unit.
- Holds up to DEPTH entries and captures source operands from the dispatch stage and from the writeback broadcast buses.
- Issues the head entry to the branch unit once both sources are ready and the branch unit requests an instruction.
- When nothing is issued, the branch-unit inputs carry a NOP micro-op, because the branch unit has no valid input.

Parameters:
- DEPTH, 8, number of queue entries; must be a power of 2.
- PTR_W, 3, log2(DEPTH).
- MOP_W, 8, micro-operate code width; must match the package's micro-op width.
- NOP_MOP, 0, micro-op code driven when no issue occurs; must decode to the branch unit's default (no-op) case.

Ports:
- Clk  in  1  clock.
- Rest  in  1  synchronous reset, active-low.
- Flash  in  1  pipeline flush.
- InValid  in  1  dispatch presents an entry.
- InReady  out  1  queue can accept; equals !full.
- InPc  in  32  instruction PC.
- InMop  in  MOP_W  micro-op.
- InSrc1Able, InSrc2Able  in  1 each  source used.
- InSrc1Ready, InSrc2Ready  in  1 each  source data valid at dispatch.
- InSrc1Addr, InSrc2Addr  in  7 each  renamed source tags.
- InSrc1Date, InSrc2Date  in  32 each  source data.
- InImm  in  26  immediate.
- InRdAble  in  1  destination write enable.
- InRdAddr  in  7  destination tag.
- InMode  in  1  predicted-taken flag.
- InReDirDate  in  32  predicted target.
- InRobPtr  in  6  ROB pointer.
- WbAble[k], WbAddr[k], WbDate[k]  in  1/7/32  five wakeup buses, k = Alu1, Alu2, Mul, Csr, Bru.
- BruReqInst  in  1  branch unit accepts this cycle.
- OutPc, OutMop, OutSrc1Able, OutSrc1Addr, OutSrc1Date, OutSrc2Able, OutSrc2Addr, OutSrc2Date, OutImm, OutRdAble, OutRdAddr, OutMode, OutReDirDate, OutRobPtr  out  matching widths  registered issue bundle.
- Count  out  PTR_W+1  occupancy.

Behaviour:
- Storage: circular buffer with head and tail pointers of PTR_W+1 bits; the extra bit is the wrap bit.
  - empty when head == tail.
  - full when the pointers are equal except for the MSB.
  - Count = tail - head.
- Enqueue: when InValid & InReady & !Flash, the entry is written at tail and tail increments.
- Source readiness at enqueue:
  - A source with Able=0 is stored as ready.
  - If Able=1 and Ready=0 and a WbAble[k] matches the tag in the same cycle, the entry stores ready=1 with WbDate[k].
- Wakeup: each cycle, every valid entry's not-ready source compares its tag with all five buses.
  - On a match, set ready and latch the data.
  - If several buses match, priority is Bru > Alu1 > Alu2 > Mul > Csr.
- Issue condition: !empty & head src1/src2 ready & BruReqInst & !Flash.
  - On the next clock, the Out* bundle is loaded from the head and head increments.
  - Issue latency: a wakeup in cycle t makes the entry issuable in t+1, and Out* is valid from t+2.
- When not issuing, OutMop <= NOP_MOP and OutRdAble <= 0 (with BruReqInst low, the branch unit is stalled). All other Out* fields are don't-care.
- Strict in-order issue: a younger ready entry never bypasses a non-ready head.
- Full queue: InReady = 0, and the same-cycle dequeue does not raise it (ready comes from registered state). Enqueue and issue in the same cycle with the queue not full: both happen, and Count is unchanged.
- Empty queue: no issue, even if InValid is high in the same cycle (no enqueue-to-issue bypass).
- Flash (priority over everything):
  - head = tail = 0, all entries invalid.
  - The enqueue in that cycle is dropped.
  - Next cycle OutMop = NOP_MOP and OutRdAble = 0.
- Reset state, when Rest = 0 at a clock edge:
  - pointers 0, Count 0, InReady 1 after reset.
  - Out* all zeros, with OutMop = NOP_MOP.
  - A reset during operation has the same effect as Flash.
- Tag 0 is a legal tag; matching is gated only by Able.

Decomposition:
- Shared package (define.v):
  - InstAddrBus, DataBus, ReNameRegBUs and MicOperateCode widths.
  - The NOP micro-op code and the branch micro-op codes.
- One sub-module, br_iq_src_wakeup, per source slot:
  - Inputs: tag, ready, data, the five WbAble/WbAddr/WbDate buses.
  - Outputs: next_ready, next_data.
  - Combinational, with the fixed priority above.
  - Instantiated 2×DEPTH times, plus 2 for the enqueue path.

Test Plan:
- Reset then enqueue BEQ (pc 0x1000, srcs ready, data 5/5) with BruReqInst=1 → OutMop=BEQ, OutPc=0x1000 two clocks after enqueue; Count returns to 0.
- Enqueue BNE with src1 tag 0x12 not ready; pulse Alu1 WbAble, WbAddr=0x12, WbDate=0xDEAD at cycle t → OutSrc1Date=0xDEAD, issue visible at t+2.
- Head not ready, second entry ready → nothing issues; after head wakeup, both issue in order on consecutive cycles.
- Enqueue 8 entries with sources not ready → InReady=0, Count=8; a 9th InValid is ignored; one wakeup plus issue → InReady=1 next cycle.
- Enqueue in the same cycle as a matching Mul wakeup on src2 tag 0x05 → entry stored ready with the Mul data.
- 3 entries queued, Flash=1 together with InValid=1 → Count=0, OutMop=NOP_MOP next cycle; the dropped entry never issues. Hold BruReqInst=0 with a ready head → no issue; raising it → issue.
